bitrev_reorder: RTL and testbench
=================================

BITREV_REORDER -- requirements
Module: bitrev_reorder

Interface
REQ-001 Parameter N, default 64; FFT frame length, power of two, 4..1024.
REQ-002 Parameter WIDTH, default 8; bit width of each real and imaginary sample component.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 enable_in  input  1  high = in_re/in_im carry a valid sample this cycle.
REQ-006 in_re  input  WIDTH  real part of the sample, two's complement, bit-reversed frame order (sdf4 output order).
REQ-007 in_im  input  WIDTH  imaginary part of the sample, two's complement.
REQ-008 enable_out  output  1  high = out_re/out_im valid this cycle.
REQ-009 out_re  output  WIDTH  real part of the output sample, natural frame order.
REQ-010 out_im  output  WIDTH  imaginary part of the output sample.

Function
REQ-011 Block SHALL reorder each N-sample frame from bit-reversed order to natural order; sample values pass through unmodified, no arithmetic.
REQ-012 Block SHALL use a ping-pong buffer of two banks, each N x 2*WIDTH.
REQ-013 The k-th accepted sample of a frame (k = 0..N-1, counted on enable_in cycles only) SHALL be written to address bitrev_log2(N)(k) of the current write bank.
REQ-014 Write counter SHALL advance only on enable_in=1; gaps of any length are allowed; no backpressure exists.
REQ-015 On acceptance of sample k=N-1, write bank SHALL toggle, counter wraps to 0, and completed bank is marked full.
REQ-016 Read FSM states: IDLE, READ; IDLE->READ in the cycle after a bank becomes full; READ->IDLE after address N-1 issued, unless the other bank is already full (then READ continues on it with no gap).
REQ-017 In READ, read address SHALL step 0,1,..,N-1 on consecutive cycles; the bank's full flag clears when address N-1 is issued.
REQ-018 Output SHALL be registered: if sample N-1 is accepted at cycle t, out index 0 is valid at t+2 and index j at t+2+j, with enable_out=1 for N consecutive cycles.
REQ-019 Back-to-back full-rate input SHALL produce back-to-back output frames, continuous enable_out, no dropped samples.
REQ-020 When enable_out=0, out_re/out_im SHALL hold 0.
REQ-021 Write and read SHALL never target the same bank in the same cycle at input rates of at most one sample per cycle; no overflow condition is reachable.

Reset
REQ-022 rst=1 SHALL immediately force enable_out=0, out_re=0, out_im=0, write counter 0, write bank 0, both full flags 0, FSM IDLE.
REQ-023 A partial frame or in-progress readout at reset SHALL be discarded; RAM contents need no reset.
REQ-024 The first sample accepted after rst deasserts SHALL be index k=0 of a new frame.

Structure
REQ-025 Shared package fft_pkg SHALL hold default N and WIDTH constants, the log2 helper, and the bit-reverse function (shared with sdf4 stages).
REQ-026 Storage SHALL be one sub-module sdp_ram: simple dual-port, 2N x 2*WIDTH, synchronous write, registered read; bank select is the address MSB.
REQ-027 Counters, full flags, FSM and output register belong in bitrev_reorder.

Verification (N=64, WIDTH=8)
REQ-028 Continuous 64-cycle frame, in_re=in_im=bitrev6(k) -> enable_out high 64 cycles starting t+2, out_re=out_im=0..63 ascending.
REQ-029 Two back-to-back frames (second: in_re=-bitrev6(k), in_im=bitrev6(k)) -> 128 consecutive enable_out cycles; second frame out_re=0,-1,..,-63, out_im=0..63.
REQ-030 Frame with enable_in on alternate cycles -> output still 64 consecutive cycles starting 2 cycles after the last accepted sample, values as REQ-028.
REQ-031 rst pulse after 30 accepted samples, then one full frame -> no enable_out before the new frame completes; then correct 64-sample output.
REQ-032 rst asserted during readout at j=10 -> enable_out, out_re, out_im 0 in the same cycle and remain 0 until a new frame completes.
REQ-033 Extreme values -128 and 127 on both components -> emerge bit-exact at the correct natural index.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared FFT definitions: default frame geometry, log2 and bit-reverse helpers,
// and the readout FSM state type used by the reorder buffer.
package fft_pkg;

  localparam int FFT_N_DEF     = 64;
  localparam int FFT_WIDTH_DEF = 8;
  localparam int BR_MAX_BITS   = 16;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_READ = 1'b1
  } rd_state_t;

  // Ceiling log2 of a positive integer (exact for powers of two).
  function automatic int log2_int(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Reverse the low 'bits' bits of v; bits above 'bits' come back as zero.
  function automatic logic [BR_MAX_BITS-1:0] bitrev(input logic [BR_MAX_BITS-1:0] v,
                                                    input int bits);
    logic [BR_MAX_BITS-1:0] r;
    r = '0;
    for (int i = 0; i < BR_MAX_BITS; i++) begin
      if (i < bits) r[bits-1-i] = v[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one synchronous write port, one registered read port.
// Contents are not reset; the caller tracks validity separately.
module sdp_ram #(
  parameter int DEPTH = 128,
  parameter int AW    = 7,
  parameter int DW    = 16
) (
  input  logic          i_clk,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [DW-1:0] i_wr_data,
  input  logic          i_rd_en,
  input  logic [AW-1:0] i_rd_addr,
  output logic [DW-1:0] o_rd_data
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rd_data;

  // Write port: store the sample when the writer presents one.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  // Read port: registered output, updated only on requested reads.
  always_ff @(posedge i_clk) begin
    if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/bitrev_reorder.sv
// Bit-reversed to natural order frame reorder using a two-bank ping-pong RAM.
// Samples are written at bit-reversed addresses and read back sequentially,
// so each frame leaves in natural order two cycles after its last sample.
module bitrev_reorder
  import fft_pkg::*;
#(
  parameter int N     = FFT_N_DEF,
  parameter int WIDTH = FFT_WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable_in,
  input  logic signed [WIDTH-1:0] in_re,
  input  logic signed [WIDTH-1:0] in_im,
  output logic                    enable_out,
  output logic signed [WIDTH-1:0] out_re,
  output logic signed [WIDTH-1:0] out_im
);

  localparam int LOGN = log2_int(N);
  localparam int AW   = LOGN + 1;
  localparam int DW   = 2 * WIDTH;
  localparam logic [LOGN-1:0] LAST = LOGN'(N - 1);

  // Write side
  logic [LOGN-1:0]        r_wr_cnt;
  logic                   r_wr_bank;
  logic                   w_wr_last;
  logic [BR_MAX_BITS-1:0] w_wr_br;
  logic [AW-1:0]          w_wr_addr;

  // Bank bookkeeping
  logic [1:0]             r_full;
  logic [1:0]             w_full_nxt;

  // Read side
  rd_state_t              r_state;
  rd_state_t              w_state_nxt;
  logic [LOGN-1:0]        r_rd_cnt;
  logic                   r_rd_bank;
  logic                   w_rd_en;
  logic                   w_rd_last;
  logic [AW-1:0]          w_rd_addr;
  logic [DW-1:0]          w_rd_data;

  // Output pipeline
  logic                   r_vld_p1;
  logic                   r_out_vld_p2;
  logic signed [WIDTH-1:0] r_out_re_p2;
  logic signed [WIDTH-1:0] r_out_im_p2;

  assign w_wr_last = enable_in && (r_wr_cnt == LAST);
  assign w_wr_br   = bitrev(BR_MAX_BITS'(r_wr_cnt), LOGN);
  assign w_wr_addr = {r_wr_bank, w_wr_br[LOGN-1:0]};

  assign w_rd_en   = (r_state == RD_READ);
  assign w_rd_last = w_rd_en && (r_rd_cnt == LAST);
  assign w_rd_addr = {r_rd_bank, r_rd_cnt};

  sdp_ram #(
    .DEPTH (2 * N),
    .AW    (AW),
    .DW    (DW)
  ) u_ram (
    .i_clk     (clk),
    .i_wr_en   (enable_in),
    .i_wr_addr (w_wr_addr),
    .i_wr_data ({in_re, in_im}),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

  // Write counter advances per accepted sample; the bank flips after the last one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_cnt  <= '0;
      r_wr_bank <= 1'b0;
    end else if (enable_in) begin
      r_wr_cnt <= r_wr_cnt + 1'b1;
      if (w_wr_last) r_wr_bank <= ~r_wr_bank;
    end
  end

  // Next full flags: readout of address N-1 frees a bank, a finished frame fills one.
  always_comb begin
    w_full_nxt = r_full;
    if (w_rd_last) w_full_nxt[r_rd_bank] = 1'b0;
    if (w_wr_last) w_full_nxt[r_wr_bank] = 1'b1;
  end

  // Full flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_full <= 2'b00;
    else     r_full <= w_full_nxt;
  end

  // Readout FSM next state: enter READ as soon as the pending bank is full,
  // chain straight into the other bank when it is already complete.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RD_IDLE: if (w_full_nxt[r_rd_bank]) w_state_nxt = RD_READ;
      RD_READ: if (w_rd_last && !w_full_nxt[~r_rd_bank]) w_state_nxt = RD_IDLE;
      default: w_state_nxt = RD_IDLE;
    endcase
  end

  // Readout state, sequential read address and read bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= RD_IDLE;
      r_rd_cnt  <= '0;
      r_rd_bank <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_rd_en)   r_rd_cnt  <= r_rd_cnt + 1'b1;
      if (w_rd_last) r_rd_bank <= ~r_rd_bank;
    end
  end

  // p1: RAM read in flight; p2: registered output, forced to zero when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p1     <= 1'b0;
      r_out_vld_p2 <= 1'b0;
      r_out_re_p2  <= '0;
      r_out_im_p2  <= '0;
    end else begin
      r_vld_p1     <= w_rd_en;
      r_out_vld_p2 <= r_vld_p1;
      if (r_vld_p1) begin
        r_out_re_p2 <= w_rd_data[DW-1:WIDTH];
        r_out_im_p2 <= w_rd_data[WIDTH-1:0];
      end else begin
        r_out_re_p2 <= '0;
        r_out_im_p2 <= '0;
      end
    end
  end

  assign enable_out = r_out_vld_p2;
  assign out_re     = r_out_re_p2;
  assign out_im     = r_out_im_p2;

endmodule

// File: tb/tb_bitrev_reorder.sv
// Directed bench for bitrev_reorder at N=64, WIDTH=8.
module tb_bitrev_reorder;

  localparam int N = 64;
  localparam int W = 8;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                enable_in = 1'b0;
  logic signed [W-1:0] in_re = '0;
  logic signed [W-1:0] in_im = '0;
  logic                enable_out;
  logic signed [W-1:0] out_re;
  logic signed [W-1:0] out_im;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bitrev_reorder #(.N(N), .WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable_in  (enable_in),
    .in_re      (in_re),
    .in_im      (in_im),
    .enable_out (enable_out),
    .out_re     (out_re),
    .out_im     (out_im)
  );

  function automatic int br6(input int k);
    logic [5:0] a, r;
    a = 6'(k);
    for (int i = 0; i < 6; i++) r[5-i] = a[i];
    return int'(r);
  endfunction

  // Value carried by natural index n in pattern p.
  function automatic logic signed [W-1:0] vre(input int p, input int n);
    case (p)
      0:       return W'(n);
      1:       return W'(-n);
      default: return (n == 5) ? 8'sh80 : (n == 60) ? 8'sh7F : W'(n);
    endcase
  endfunction

  function automatic logic signed [W-1:0] vim(input int p, input int n);
    case (p)
      0, 1:    return W'(n);
      default: return (n == 5) ? 8'sh7F : (n == 60) ? 8'sh80 : W'(63 - n);
    endcase
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic en,
                         input logic signed [W-1:0] re, input logic signed [W-1:0] im);
    chk({tag, ".en"}, 32'(enable_out), 32'(en));
    chk({tag, ".re"}, 32'(out_re), 32'(re));
    chk({tag, ".im"}, 32'(out_im), 32'(im));
  endtask

  task automatic frame_in(input int p, input bit gap, input string tag);
    for (int k = 0; k < N; k++) begin
      enable_in = 1'b1;
      in_re = vre(p, br6(k));
      in_im = vim(p, br6(k));
      cyc();
      chk($sformatf("%s.idle%0d", tag, k), 32'(enable_out), 32'd0);
      if (gap && k != N - 1) begin
        enable_in = 1'b0;
        in_re = '0;
        in_im = '0;
        cyc();
        chk($sformatf("%s.gap%0d", tag, k), 32'(enable_out), 32'd0);
      end
    end
    enable_in = 1'b0;
    in_re = '0;
    in_im = '0;
  endtask

  task automatic frame_out(input int p, input string tag);
    cyc();
    chk_out({tag, ".t1"}, 1'b0, '0, '0);
    cyc();
    for (int j = 0; j < N; j++) begin
      chk_out($sformatf("%s.o%0d", tag, j), 1'b1, vre(p, j), vim(p, j));
      cyc();
    end
    chk_out({tag, ".post"}, 1'b0, '0, '0);
  endtask

  initial begin
    // Reset state
    #1 rst = 1'b1;
    #1;
    chk_out("rst0", 1'b0, '0, '0);
    cyc();
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk_out($sformatf("idle%0d", i), 1'b0, '0, '0);
    end

    // Single continuous frame
    frame_in(0, 1'b0, "f1");
    frame_out(0, "f1");

    // Two back-to-back frames, checked every cycle
    for (int c = 0; c < 2 * N + 70; c++) begin
      int o;
      if (c < 2 * N) begin
        enable_in = 1'b1;
        in_re = vre((c < N) ? 0 : 1, br6(c % N));
        in_im = vim((c < N) ? 0 : 1, br6(c % N));
      end else begin
        enable_in = 1'b0;
        in_re = '0;
        in_im = '0;
      end
      cyc();
      o = c - (N + 1);
      if (o >= 0 && o < 2 * N)
        chk_out($sformatf("b2b.c%0d", c), 1'b1, vre((o < N) ? 0 : 1, o % N),
                vim((o < N) ? 0 : 1, o % N));
      else
        chk_out($sformatf("b2b.c%0d", c), 1'b0, '0, '0);
    end

    // Input on alternate cycles
    frame_in(0, 1'b1, "alt");
    frame_out(0, "alt");

    // Partial frame discarded by reset
    for (int k = 0; k < 30; k++) begin
      enable_in = 1'b1;
      in_re = 8'sh55;
      in_im = 8'sh55;
      cyc();
    end
    enable_in = 1'b0;
    in_re = '0;
    in_im = '0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    chk_out("part.after_rst", 1'b0, '0, '0);
    frame_in(0, 1'b0, "part");
    frame_out(0, "part");

    // Reset during readout at j=10
    frame_in(1, 1'b0, "mid");
    cyc();
    cyc();
    for (int j = 0; j < 10; j++) begin
      chk_out($sformatf("mid.o%0d", j), 1'b1, vre(1, j), vim(1, j));
      cyc();
    end
    chk_out("mid.o10", 1'b1, vre(1, 10), vim(1, 10));
    rst = 1'b1;
    #1;
    chk_out("mid.async", 1'b0, '0, '0);
    cyc();
    chk_out("mid.hold", 1'b0, '0, '0);
    rst = 1'b0;
    for (int i = 0; i < 80; i++) begin
      cyc();
      chk_out($sformatf("mid.quiet%0d", i), 1'b0, '0, '0);
    end

    // Extreme values at natural indices 5 and 60
    frame_in(2, 1'b0, "ext");
    frame_out(2, "ext");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
